// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader sitting in front of the fetch stage. Consumes a
//   byte stream made of a 16-bit word count (low byte first), 4*N payload
//   bytes and one XOR checksum byte. Payload bytes are packed little-endian
//   into 32-bit words and written into the instruction BRAM. pc_stall stays
//   high until a load finishes with a good checksum and no overflow.
//
// Ports
//   clk       in   core clock (single domain)
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse, begins a load from IDLE, DONE or ERR
//   s_data    in   stream byte
//   s_valid   in   stream byte valid
//   s_ready   out  loader accepts s_data this cycle
//   i_w_addr  out  BRAM write byte address
//   i_w_dat   out  BRAM write data
//   i_w_enb   out  BRAM write enable, one-cycle pulse per word
//   pc_stall  out  freezes the PC unless the last load completed cleanly
//   busy      out  a load is in progress
//   done      out  last load completed with good checksum and no overflow
//   err       out  last load failed (checksum mismatch or overflow)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter int unsigned            DEPTH_WORDS = 1024,
   parameter logic [DATA_WIDTH-1:0]  BASE_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic                  pc_stall,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   logic [2:0]  state;
   logic [15:0] len;        // word count taken from the header
   logic [15:0] word_cnt;   // index of the word currently being assembled
   logic [1:0]  byte_idx;   // byte position within the current word
   logic [23:0] pack;       // first three bytes of the current word
   logic [7:0]  csum;
   logic        ovf;        // sticky: some word fell beyond the BRAM
   logic        accept;

   assign s_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
   assign busy     = s_ready;
   assign pc_stall = (state != S_DONE);
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);
   assign accept   = s_valid && s_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         len      <= '0;
         word_cnt <= '0;
         byte_idx <= '0;
         pack     <= '0;
         csum     <= '0;
         ovf      <= 1'b0;
         i_w_enb  <= 1'b0;
         i_w_addr <= BASE_ADDR;
         i_w_dat  <= '0;
      end else begin
         i_w_enb <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN_LO;
                  csum     <= '0;
                  ovf      <= 1'b0;
                  word_cnt <= '0;
                  byte_idx <= '0;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= s_data;
                  state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= s_data;
                  state     <= ({s_data, len[7:0]} == 16'd0) ? S_CSUM : S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  csum     <= csum ^ s_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: pack[7:0]   <= s_data;
                     2'd1: pack[15:8]  <= s_data;
                     2'd2: pack[23:16] <= s_data;
                     default: begin
                        // Word complete: write it next cycle unless it lies past the BRAM.
                        if (32'(word_cnt) < DEPTH_WORDS) begin
                           i_w_enb  <= 1'b1;
                           i_w_dat  <= DATA_WIDTH'({s_data, pack});
                           i_w_addr <= BASE_ADDR + DATA_WIDTH'({word_cnt, 2'b00});
                        end else begin
                           ovf <= 1'b1;
                        end
                        word_cnt <= word_cnt + 16'd1;
                        if (word_cnt == len - 16'd1)
                           state <= S_CSUM;
                     end
                  endcase
               end
            end
            S_CSUM: begin
               if (accept)
                  state <= ((s_data != csum) || ovf) ? S_ERR : S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader (DEPTH_WORDS=2 so overflow is easy to
//   reach). Directed loads come from a vector table; random loads are checked
//   against a stream-level reference model (XOR of payload, min(N,DEPTH)
//   writes at BASE+4w holding the little-endian packed payload).
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] i_w_addr;
   logic [31:0] i_w_dat;
   logic        i_w_enb;
   logic        pc_stall;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .i_w_addr (i_w_addr),
      .i_w_dat  (i_w_dat),
      .i_w_enb  (i_w_enb),
      .pc_stall (pc_stall),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Write monitor, sampled mid-cycle.
   logic [63:0] wq[$];
   int          enb_viol = 0;
   logic        prev_enb = 1'b0;
   always @(negedge clk) begin
      if (i_w_enb) wq.push_back({i_w_addr, i_w_dat});
      if (i_w_enb && prev_enb) enb_viol++;
      prev_enb = i_w_enb;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " s_ready"},  {31'd0, s_ready},  32'd0);
      chk({tag, " i_w_enb"},  {31'd0, i_w_enb},  32'd0);
      chk({tag, " i_w_addr"}, i_w_addr,          BASE);
      chk({tag, " i_w_dat"},  i_w_dat,           32'd0);
      chk({tag, " pc_stall"}, {31'd0, pc_stall}, 32'd1);
      chk({tag, " busy"},     {31'd0, busy},     32'd0);
      chk({tag, " done"},     {31'd0, done},     32'd0);
      chk({tag, " err"},      {31'd0, err},      32'd0);
   endtask

   // Presents one byte and returns right after the edge where it transferred.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      s_data  = b;
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 50) begin
         tick();
         n++;
      end
      if (!s_ready) chk("ready_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // Runs one full load and checks it against the reference model.
   task automatic run_load(input string tag, input int n, input logic [127:0] pl,
                           input logic [7:0] ck, input bit gaps, input bit midstart,
                           output bit got_done, output int got_nwr);
      logic [7:0] x;
      bit         good;
      int         nexp;
      int         w;
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) x ^= pl[8*i +: 8];
      good = (ck == x) && (n <= int'(DEPTH));
      nexp = (n < int'(DEPTH)) ? n : int'(DEPTH);

      wq.delete();
      pulse_start();
      chk({tag, " start busy"},     {31'd0, busy},     32'd1);
      chk({tag, " start pc_stall"}, {31'd0, pc_stall}, 32'd1);
      chk({tag, " start done"},     {31'd0, done},     32'd0);
      chk({tag, " start err"},      {31'd0, err},      32'd0);

      send_byte(n[7:0], gaps);
      send_byte(n[15:8], gaps);
      for (int i = 0; i < 4 * n; i++) begin
         send_byte(pl[8*i +: 8], gaps);
         w = i / 4;
         if ((i % 4) == 3 && w < int'(DEPTH)) begin
            chk({tag, " enb_latency"}, {31'd0, i_w_enb}, 32'd1);
            chk({tag, " enb_addr"},    i_w_addr, BASE + 32'(4 * w));
            chk({tag, " enb_dat"},     i_w_dat,  pl[32*w +: 32]);
         end else begin
            chk({tag, " enb_quiet"},   {31'd0, i_w_enb}, 32'd0);
         end
         if (midstart && i == 1) begin
            s_valid = 1'b0;
            pulse_start();   // ignored while busy
         end
      end
      send_byte(ck, gaps);
      s_valid = 1'b0;

      chk({tag, " done"},     {31'd0, done},     {31'd0, good});
      chk({tag, " err"},      {31'd0, err},      {31'd0, !good});
      chk({tag, " pc_stall"}, {31'd0, pc_stall}, {31'd0, !good});
      chk({tag, " busy"},     {31'd0, busy},     32'd0);
      chk({tag, " nwr"},      wq.size(),         32'(nexp));
      for (int k = 0; k < nexp && k < wq.size(); k++) begin
         chk({tag, " wr_addr"}, wq[k][63:32], BASE + 32'(4 * k));
         chk({tag, " wr_dat"},  wq[k][31:0],  pl[32*k +: 32]);
      end
      repeat (3) tick();
      chk({tag, " hold done"}, {31'd0, done}, {31'd0, good});
      got_done = done;
      got_nwr  = wq.size();
   endtask

   typedef struct packed {
      logic [15:0]  n;
      logic [127:0] pl;
      logic [7:0]   ck;
      logic         gaps;
      logic         midstart;
      logic         exp_done;
      logic [7:0]   exp_nwr;
   } vec_t;

   localparam logic [127:0] P1 = 128'h0010_0093_0000_0013;
   localparam logic [127:0] P3 = 128'h0C0B_0A09_0807_0605_0403_0201;

   vec_t vecs[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          gd;
      int          nw;
      logic [127:0] rpl;
      logic [7:0]  rx;
      int          rn;

      // Payload 13 00 00 00 93 00 10 00 XORs to 0x90.
      vecs[0] = '{16'd2, P1, 8'h90, 1'b0, 1'b0, 1'b1, 8'd2};
      vecs[1] = '{16'd2, P1, 8'h91, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[2] = '{16'd2, P1, 8'h80, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[3] = '{16'd3, P3, 8'h0C, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[4] = '{16'd0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[5] = '{16'd0, '0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[6] = '{16'd2, P1, 8'h90, 1'b1, 1'b0, 1'b1, 8'd2};
      vecs[7] = '{16'd2, P1, 8'h90, 1'b0, 1'b1, 1'b1, 8'd2};
      vecs[8] = '{16'd1, 128'hDEAD_BEEF, 8'h22, 1'b0, 1'b0, 1'b1, 8'd1};

      rst = 1'b0; start = 1'b0; s_data = 8'h00; s_valid = 1'b0;
      repeat (3) tick();
      check_reset("reset");
      rst = 1'b1;
      s_valid = 1'b1;
      repeat (2) tick();
      chk("idle s_ready", {31'd0, s_ready}, 32'd0);
      s_valid = 1'b0;

      for (int v = 0; v < 9; v++) begin
         run_load($sformatf("vec%0d", v), int'(vecs[v].n), vecs[v].pl, vecs[v].ck,
                  vecs[v].gaps, vecs[v].midstart, gd, nw);
         chk($sformatf("vec%0d tbl_done", v), {31'd0, gd}, {31'd0, vecs[v].exp_done});
         chk($sformatf("vec%0d tbl_nwr", v),  nw, {24'd0, vecs[v].exp_nwr});
      end

      // Reset in the middle of a load, after 6 payload bytes.
      wq.delete();
      pulse_start();
      send_byte(8'd2, 1'b0);
      send_byte(8'd0, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(P1[8*i +: 8], 1'b0);
      s_valid = 1'b0;
      #2 rst = 1'b0;
      #1 check_reset("midreset");
      chk("midreset nwr", wq.size(), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("start_in_reset busy", {31'd0, busy}, 32'd0);
      run_load("after_reset", 2, P1, 8'h90, 1'b0, 1'b0, gd, nw);

      // Random loads against the reference model.
      for (int r = 0; r < 24; r++) begin
         rn  = $urandom_range(0, 4);
         rpl = {$urandom, $urandom, $urandom, $urandom};
         rx  = 8'h00;
         for (int i = 0; i < 4 * rn; i++) rx ^= rpl[8*i +: 8];
         if ($urandom_range(0, 3) == 0) rx ^= 8'(1 << $urandom_range(0, 7));
         run_load($sformatf("rnd%0d", r), rn, rpl, rx, 1'($urandom_range(0, 1)),
                  1'b0, gd, nw);
      end

      chk("enb_pulse_width", enb_viol, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
